// File: rtl/instruction_fetch.sv
// Instruction fetch front end: credit-limited request stream, in-order response pairing,
// fetch queue toward decode, redirect flush with drop counting for stale responses.
module instruction_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                    FQ_DEPTH   = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  output logic                             imem_req_valid,
  input  logic                             imem_req_ready,
  output logic [ADDR_WIDTH-1:0]            imem_req_addr,
  input  logic                             imem_resp_valid,
  input  logic [DATA_WIDTH-1:0]            imem_resp_data,
  input  logic                             redirect_valid,
  input  logic [ADDR_WIDTH-1:0]            redirect_addr,
  output logic [ADDR_WIDTH+DATA_WIDTH:0]   instruction,
  input  logic                             instr_ready
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FQ_DEPTH);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [CW-1:0]         r_outstanding;
  logic [CW-1:0]         r_drop_cnt;

  logic [ADDR_WIDTH-1:0] r_af_mem [FQ_DEPTH];
  logic [PW-1:0]         r_af_wr;
  logic [PW-1:0]         r_af_rd;

  logic [ADDR_WIDTH-1:0] r_q_addr [FQ_DEPTH];
  logic [DATA_WIDTH-1:0] r_q_data [FQ_DEPTH];
  logic [PW-1:0]         r_q_wr;
  logic [PW-1:0]         r_q_rd;
  logic [CW-1:0]         r_q_cnt;

  logic [ADDR_WIDTH-1:0] w_pc_aligned;
  logic [CW:0]           w_credit_used;
  logic                  w_req_fire;
  logic                  w_resp_keep;
  logic                  w_resp_drop;
  logic                  w_instr_valid;
  logic                  w_deq;

  // In-flight requests plus queued words may never exceed the queue size,
  // so every accepted request is guaranteed a slot when its response lands.
  assign w_pc_aligned   = {r_pc[ADDR_WIDTH-1:2], 2'b00};
  assign w_credit_used  = {1'b0, r_outstanding} + {1'b0, r_q_cnt};
  assign imem_req_valid = rst_n & ~redirect_valid & (w_credit_used < DEPTH_W);
  assign imem_req_addr  = w_pc_aligned;
  assign w_req_fire     = imem_req_valid & imem_req_ready;

  assign w_resp_drop    = imem_resp_valid & (r_drop_cnt != '0);
  assign w_resp_keep    = imem_resp_valid & ~redirect_valid & (r_drop_cnt == '0);
  assign w_instr_valid  = (r_q_cnt != '0) & ~redirect_valid;
  assign w_deq          = w_instr_valid & instr_ready;

  assign instruction    = {r_q_addr[r_q_rd], r_q_data[r_q_rd], w_instr_valid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= {redirect_addr[ADDR_WIDTH-1:2], 2'b00};
    end else if (w_req_fire) begin
      r_pc <= r_pc + ADDR_WIDTH'(4);
    end
  end

  // Responses already in flight at a redirect belong to the old path and are
  // discarded as they return; the one arriving in the redirect cycle is dropped directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(imem_resp_valid);
      if (redirect_valid) begin
        r_drop_cnt <= r_outstanding - CW'(imem_resp_valid);
      end else if (w_resp_drop) begin
        r_drop_cnt <= r_drop_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_af_mem[r_af_wr] <= w_pc_aligned;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_af_wr <= '0;
      r_af_rd <= '0;
    end else begin
      if (w_req_fire) begin
        r_af_wr <= r_af_wr + PW'(1);
      end
      if (imem_resp_valid) begin
        r_af_rd <= r_af_rd + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FQ_DEPTH; i++) begin
        r_q_addr[i] <= '0;
        r_q_data[i] <= '0;
      end
      r_q_wr  <= '0;
      r_q_rd  <= '0;
      r_q_cnt <= '0;
    end else if (redirect_valid) begin
      r_q_rd  <= r_q_wr;
      r_q_cnt <= '0;
    end else begin
      if (w_resp_keep) begin
        r_q_addr[r_q_wr] <= r_af_mem[r_af_rd];
        r_q_data[r_q_wr] <= imem_resp_data;
        r_q_wr           <= r_q_wr + PW'(1);
      end
      if (w_deq) begin
        r_q_rd <= r_q_rd + PW'(1);
      end
      r_q_cnt <= r_q_cnt + CW'(w_resp_keep) - CW'(w_deq);
    end
  end

endmodule
